// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry,
// header width and the loader state encoding.
package imem_loader_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;
  localparam int HDR_W      = 16;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word assembler: shifts bytes in big-endian order and emits a
// registered one-cycle word_valid pulse with the completed word.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // The byte currently accepted completes a word.
  assign word_last = byte_en && (cnt == 2'd3);

  // Shift bytes in; on the fourth byte latch the word and pulse word_valid.
  // word holds its last value between pulses; clr only drops a partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 2'd0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      cnt        <= 2'd0;
      shift      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        cnt   <= cnt + 2'd1;
        shift <= {shift[15:0], byte_in};
        if (cnt == 2'd3) begin
          word       <= {shift, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory and holds
// the CPU in reset until the image has been written completely.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  state_t             state;
  logic [7:0]         len_hi;
  logic [ADDR_W:0]    count;   // words expected; one extra bit so DEPTH fits
  logic [ADDR_W:0]    wcnt;    // words completed so far
  logic [HDR_W-1:0]   hdr;
  logic               accept;
  logic               load_go;
  logic               byte_en;
  logic               word_last;

  assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign accept   = in_valid && in_ready;
  assign load_go  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign byte_en  = accept && (state == DATA);
  assign hdr      = {len_hi, in_data};

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_go),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_last  (word_last),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  // Loader FSM: header parse, word counting, write address and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_hi  <= '0;
      count   <= '0;
      wcnt    <= '0;
      wr_addr <= '0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state   <= LEN_HI;
            done    <= 1'b0;
            err     <= 1'b0;
            cpu_rst <= 1'b1;
            wcnt    <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            if (hdr == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else if (32'(hdr) > DEPTH) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              count <= hdr[ADDR_W:0];
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_last) begin
            wr_addr <= wcnt[ADDR_W-1:0];
            wcnt    <= wcnt + 1'b1;
            if ((wcnt + 1'b1) == count) state <= FINISH;
          end
        end
        FINISH: begin
          state   <= DONE;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the short
// protocol scenarios plus hand-written sequences for reset and full depth.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int tests  = 0;
  int fails  = 0;
  int exp_idx = 0;
  int nwr     = 0;

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [9:0]  a;
    logic [31:0] wd;
    logic        dn;
    logic        er;
    logic        cr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic st, input logic v, input logic [7:0] d,
                              input logic rdy, input logic we, input logic [9:0] a,
                              input logic [31:0] wd, input logic dn, input logic er,
                              input logic cr);
    vec_t t;
    t.st = st; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.a = a;
    t.wd = wd; t.dn = dn; t.er = er; t.cr = cr;
    vecs.push_back(t);
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return {8'(i), 8'(i >> 8), 8'hC3, 8'(i * 7 + 1)};
  endfunction

  // One clock; any write seen must be the next expected word in order.
  task automatic step_mon();
    @(posedge clk); #1;
    if (wr_en) begin
      chk($sformatf("wr_addr_%0d", exp_idx), 32'(wr_addr), 32'(exp_idx));
      chk($sformatf("wr_data_%0d", exp_idx), wr_data, word_of(exp_idx));
      exp_idx++;
      nwr++;
    end
  endtask

  // start, header n, then nbytes data bytes streamed back-to-back.
  task automatic send_load(input int n, input int nbytes);
    logic [31:0] w;
    exp_idx = 0;
    nwr     = 0;
    start = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    step_mon();
    start = 1'b0; in_valid = 1'b1; in_data = 8'(n >> 8);
    step_mon();
    in_data = 8'(n);
    step_mon();
    for (int b = 0; b < nbytes; b++) begin
      w = word_of(b / 4);
      in_data = w[31 - 8 * (b % 4) -: 8];
      step_mon();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // Reset with start held high: reset must win.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  wr_data,       32'd0);
    chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    rst = 1'b0; start = 1'b0;

    //   st v  d       rdy we a  wd            dn er cr
    // Two words back-to-back
    add(1, 0, 8'h00,  1, 0, 0, 32'h0,         0, 0, 1);
    add(0, 1, 8'h00,  1, 0, 0, 32'h0,         0, 0, 1);
    add(0, 1, 8'h02,  1, 0, 0, 32'h0,         0, 0, 1);
    add(0, 1, 8'h20,  1, 0, 0, 32'h0,         0, 0, 1);
    add(0, 1, 8'h08,  1, 0, 0, 32'h0,         0, 0, 1);
    add(0, 1, 8'h00,  1, 0, 0, 32'h0,         0, 0, 1);
    add(0, 1, 8'h05,  1, 1, 0, 32'h20080005,  0, 0, 1);
    add(0, 1, 8'hAC,  1, 0, 0, 32'h20080005,  0, 0, 1);
    add(0, 1, 8'h09,  1, 0, 0, 32'h20080005,  0, 0, 1);
    add(0, 1, 8'h00,  1, 0, 0, 32'h20080005,  0, 0, 1);
    add(0, 1, 8'h00,  0, 1, 1, 32'hAC090000,  0, 0, 1);
    add(0, 0, 8'h00,  0, 0, 1, 32'hAC090000,  1, 0, 0);
    // Zero-length image
    add(1, 0, 8'h00,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h00,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h00,  0, 0, 1, 32'hAC090000,  1, 0, 0);
    // Oversized header 1025
    add(1, 0, 8'h00,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h04,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h01,  0, 0, 1, 32'hAC090000,  0, 1, 1);
    add(0, 1, 8'h55,  0, 0, 1, 32'hAC090000,  0, 1, 1);
    add(0, 0, 8'h00,  0, 0, 1, 32'hAC090000,  0, 1, 1);
    // One word, in_valid every other cycle, start ignored mid-load
    add(1, 0, 8'h00,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h00,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h01,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 0, 8'hEE,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h12,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(1, 0, 8'hEE,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h34,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 0, 8'hEE,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h56,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 0, 8'hEE,  1, 0, 1, 32'hAC090000,  0, 0, 1);
    add(0, 1, 8'h78,  0, 1, 0, 32'h12345678,  0, 0, 1);
    add(0, 1, 8'h99,  0, 0, 0, 32'h12345678,  1, 0, 0);
    add(0, 1, 8'h99,  0, 0, 0, 32'h12345678,  1, 0, 0);

    foreach (vecs[i]) begin
      start = vecs[i].st; in_valid = vecs[i].v; in_data = vecs[i].d;
      @(posedge clk); #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_wr_en",    i), 32'(wr_en),    32'(vecs[i].we));
      chk($sformatf("v%0d_wr_addr",  i), 32'(wr_addr),  32'(vecs[i].a));
      chk($sformatf("v%0d_wr_data",  i), wr_data,       vecs[i].wd);
      chk($sformatf("v%0d_done",     i), 32'(done),     32'(vecs[i].dn));
      chk($sformatf("v%0d_err",      i), 32'(err),      32'(vecs[i].er));
      chk($sformatf("v%0d_cpu_rst",  i), 32'(cpu_rst),  32'(vecs[i].cr));
    end
    start = 1'b0; in_valid = 1'b0;

    // Reset after two bytes of word 3 of a 5-word load.
    send_load(5, 14);
    chk("midrst_writes_before", 32'(nwr), 32'd3);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAB;
    @(posedge clk); #1;
    chk("midrst_wr_en",    32'(wr_en),    32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("midrst_wr_addr",  32'(wr_addr),  32'd0);
    chk("midrst_wr_data",  wr_data,       32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d_wr_en", k),    32'(wr_en),    32'd0);
      chk($sformatf("idle%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Fresh load after the aborted one starts again at address 0.
    send_load(2, 8);
    chk("reload_finish_in_ready", 32'(in_ready), 32'd0);
    step_mon();
    chk("reload_writes",  32'(nwr),     32'd2);
    chk("reload_done",    32'(done),    32'd1);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd0);

    // Full depth: last write lands on 1023 and nothing wraps.
    send_load(1024, 4096);
    step_mon();
    chk("full_writes",   32'(nwr),     32'd1024);
    chk("full_done",     32'(done),    32'd1);
    chk("full_cpu_rst",  32'(cpu_rst), 32'd0);
    chk("full_wr_addr",  32'(wr_addr), 32'd1023);
    chk("full_wr_en",    32'(wr_en),   32'd0);
    chk("full_err",      32'(err),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
